// File: rtl/evt_rr_dispatcher.sv
// Round-robin event dispatcher: sticky pending bits from pulse inputs, one
// eligible index offered at a time over valid/ready, rotating priority.
module evt_rr_dispatcher #(
  parameter int NUM_EVT = 8,
  parameter int IDX_W   = $clog2(NUM_EVT)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [NUM_EVT-1:0] mask_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o,
  input  logic               ready_i,
  output logic [NUM_EVT-1:0] pending_o,
  output logic               overflow_o
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t             state_q;
  logic [NUM_EVT-1:0] pend_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   idx_q;
  logic               valid_q;
  logic               ovf_q;

  logic [NUM_EVT-1:0] elig;
  logic [NUM_EVT-1:0] clr;
  logic [NUM_EVT-1:0] e2;
  logic [NUM_EVT-1:0] pend_d;
  logic               ovf_d;
  logic               hs;
  logic [IDX_W-1:0]   ptr_d;
  logic [IDX_W-1:0]   sel_idle;
  logic [IDX_W-1:0]   sel_next;

  // Lowest set index at or above p; falls back to the lowest set index overall.
  function automatic logic [IDX_W-1:0] sel(input logic [NUM_EVT-1:0] v,
                                           input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] lo;
    logic [IDX_W-1:0] hi;
    logic             hi_found;
    lo       = '0;
    hi       = '0;
    hi_found = 1'b0;
    for (int i = NUM_EVT - 1; i >= 0; i--) begin
      if (v[i]) begin
        lo = IDX_W'(i);
        if (i >= int'(p)) begin
          hi       = IDX_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    return hi_found ? hi : lo;
  endfunction

  always_comb begin
    elig     = pend_q & ~mask_i;
    hs       = (state_q == OFFER) && ready_i;
    clr      = '0;
    if (hs) clr[idx_q] = 1'b1;
    e2       = elig & ~clr;
    ptr_d    = (idx_q == IDX_W'(NUM_EVT - 1)) ? '0 : idx_q + 1'b1;
    pend_d   = (pend_q & ~clr) | evt_i;
    ovf_d    = |(evt_i & pend_q & ~clr);
    sel_idle = sel(elig, ptr_q);
    sel_next = sel(e2, ptr_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (clear_i) begin
      // Flush retracts any offer; idx is left as-is since valid qualifies it.
      state_q <= IDLE;
      pend_q  <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      case (state_q)
        IDLE: begin
          if (|elig) begin
            idx_q   <= sel_idle;
            valid_q <= 1'b1;
            state_q <= OFFER;
          end
        end
        OFFER: begin
          if (ready_i) begin
            ptr_q <= ptr_d;
            if (|e2) begin
              idx_q <= sel_next;
            end else begin
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o    = valid_q;
  assign idx_o      = idx_q;
  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_evt_rr_dispatcher.sv
// Bench for evt_rr_dispatcher: directed scenarios with literal expectations,
// then random traffic compared every cycle against a rotating-search model.
module tb_evt_rr_dispatcher;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic [N-1:0] evt;
  logic [N-1:0] mask;
  logic         ready;
  logic         valid_o;
  logic [2:0]   idx_o;
  logic [N-1:0] pending_o;
  logic         overflow_o;

  evt_rr_dispatcher #(.NUM_EVT(N)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (clear),
    .evt_i      (evt),
    .mask_i     (mask),
    .valid_o    (valid_o),
    .idx_o      (idx_o),
    .ready_i    (ready),
    .pending_o  (pending_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // Model: pending bits, pointer, current offer.
  logic [N-1:0] m_pend;
  int           m_ptr;
  bit           m_valid;
  int           m_idx;
  bit           m_ovf;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Scan upward from p, wrapping, for the first set bit.
  function automatic int rr(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_pend = '0; m_ptr = 0; m_valid = 0; m_idx = 0; m_ovf = 0;
  endtask

  task automatic m_step();
    logic [N-1:0] elig, e2, np;
    bit hs;
    if (clear) begin
      m_pend = '0; m_ptr = 0; m_valid = 0; m_ovf = 0;
      return;
    end
    hs   = m_valid && ready;
    elig = m_pend & ~mask;
    np   = m_pend;
    if (hs) np[m_idx] = 1'b0;
    m_ovf = |(evt & np);
    np = np | evt;
    if (!m_valid) begin
      if (elig != 0) begin m_idx = rr(elig, m_ptr); m_valid = 1; end
    end else if (hs) begin
      m_ptr = (m_idx + 1) % N;
      e2 = elig;
      e2[m_idx] = 1'b0;
      if (e2 != 0) m_idx = rr(e2, m_ptr);
      else m_valid = 0;
    end
    m_pend = np;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("valid", int'(valid_o), int'(m_valid));
      chk("idx", int'(idx_o), m_idx);
      chk("pending", int'(pending_o), int'(m_pend));
      chk("overflow", int'(overflow_o), int'(m_ovf));
    end
  end

  task automatic idle_in();
    evt = '0; clear = 0;
  endtask

  initial begin
    rst_n = 0; clear = 0; evt = '0; mask = '0; ready = 0;
    m_reset();
    cyc(); cyc();
    rst_n = 1;
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_idx", int'(idx_o), 0);
    chk("reset_pending", int'(pending_o), 0);
    chk("reset_ovf", int'(overflow_o), 0);
    cmp_en = 1;

    // Single event, ready high
    ready = 1; evt = 8'h10; cyc(); idle_in();
    chk("single_pend", int'(pending_o), 'h10);
    chk("single_nvalid", int'(valid_o), 0);
    cyc();
    chk("single_valid", int'(valid_o), 1);
    chk("single_idx", int'(idx_o), 4);
    cyc();
    $display("txn single: valid=%0d pending=%02h", valid_o, pending_o);
    chk("single_done_valid", int'(valid_o), 0);
    chk("single_done_pend", int'(pending_o), 0);

    // Round robin from ptr=0
    clear = 1; cyc(); clear = 0;
    evt = 8'hA5; cyc(); idle_in();
    cyc(); chk("rr0_a", int'(idx_o), 0);
    cyc(); chk("rr0_b", int'(idx_o), 2);
    cyc(); chk("rr0_c", int'(idx_o), 5);
    cyc(); chk("rr0_d", int'(idx_o), 7);
    cyc(); chk("rr0_end", int'(valid_o), 0);
    $display("txn rr ptr0 done: pending=%02h", pending_o);

    // Move ptr to 6 by accepting index 5, then repeat
    evt = 8'h20; cyc(); idle_in(); cyc(); cyc();
    evt = 8'hA5; cyc(); idle_in();
    cyc(); chk("rr6_a", int'(idx_o), 7);
    cyc(); chk("rr6_b", int'(idx_o), 0);
    cyc(); chk("rr6_c", int'(idx_o), 2);
    cyc(); chk("rr6_d", int'(idx_o), 5);
    cyc(); chk("rr6_end", int'(valid_o), 0);
    $display("txn rr ptr6 done: pending=%02h", pending_o);

    // Backpressure with mask change mid-offer (ptr=6 -> first offer is 1)
    ready = 0; evt = 8'h06; cyc(); idle_in();
    for (int c = 0; c < 5; c++) begin
      if (c == 2) mask = 8'h02;
      cyc();
      chk("bp_valid", int'(valid_o), 1);
      chk("bp_idx", int'(idx_o), 1);
    end
    ready = 1; cyc();
    chk("bp_next_idx", int'(idx_o), 2);
    chk("bp_pend_mid", int'(pending_o), 'h04);
    cyc();
    chk("bp_pend_end", int'(pending_o), 0);
    chk("bp_valid_end", int'(valid_o), 0);
    $display("txn backpressure done: pending=%02h", pending_o);
    mask = '0;

    // Same-cycle re-arm on handshake of idx 3 (ptr=3)
    ready = 0; evt = 8'h08; cyc(); idle_in(); cyc();
    chk("rearm_offer", int'(idx_o), 3);
    ready = 1; evt = 8'h08; cyc(); idle_in();
    chk("rearm_pend", int'(pending_o), 'h08);
    chk("rearm_ovf", int'(overflow_o), 0);
    cyc(); cyc();
    $display("txn rearm done: pending=%02h", pending_o);

    // Overflow on already-pending bit 0, no handshake
    ready = 0; evt = 8'h01; cyc(); cyc(); idle_in();
    chk("ovf_pulse", int'(overflow_o), 1);
    cyc();
    chk("ovf_clear", int'(overflow_o), 0);
    $display("txn overflow done: valid=%0d idx=%0d", valid_o, idx_o);

    // Clear during offer drops same-cycle events
    clear = 1; evt = 8'hFF; cyc(); idle_in();
    chk("clr_valid", int'(valid_o), 0);
    chk("clr_pend", int'(pending_o), 0);
    chk("clr_ovf", int'(overflow_o), 0);
    ready = 1; evt = 8'h81; cyc(); idle_in(); cyc();
    chk("clr_restart", int'(idx_o), 0);
    cyc(); chk("clr_restart2", int'(idx_o), 7);
    cyc();
    $display("txn clear done: valid=%0d", valid_o);

    // Async reset mid-offer
    ready = 0; evt = 8'h04; cyc(); idle_in(); cyc();
    #2 rst_n = 0;
    #1;
    m_reset();
    chk("arst_valid", int'(valid_o), 0);
    chk("arst_idx", int'(idx_o), 0);
    chk("arst_pend", int'(pending_o), 0);
    chk("arst_ovf", int'(overflow_o), 0);
    cyc(); rst_n = 1;
    $display("txn async reset done");

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      evt   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      ready = ($urandom_range(0, 9) < 7);
      clear = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) mask = N'($urandom) & N'($urandom);
      cyc();
      if (valid_o && ready) $display("txn rand c=%0d accept idx=%0d", c, idx_o);
    end
    idle_in();
    cyc();
    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
